i2s_dac_tx: RTL and testbench

I2S transmitter for the equalizer output path. It takes the 16-bit signed left and right samples produced by the equalizer core and serializes them MSB-first to the codec DAC. It also generates the codec clocks MCLK, SCLK and LRCLK from the system clock. It is the outbound counterpart of the codec receive path that supplies the core's `lft_in`/`rht_in`/`valid`, and it sits between the core outputs and the codec pins.

---
 rtl/codec_pkg.sv | 17 +
 rtl/i2s_ser.sv | 50 +++++
 rtl/i2s_dac_tx.sv | 97 +++++++++
 tb/tb_i2s_dac_tx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared codec timing constants for the I2S transmit path.
// All clocks and slot positions are derived from one free-running counter.
package codec_pkg;

  localparam int CNT_W     = 11;
  localparam int MCLK_BIT  = 1;
  localparam int SCLK_BIT  = 4;
  localparam int LRCLK_BIT = 10;
  localparam int SLOT_W    = 5;
  localparam int I2S_DELAY = 1;

  localparam logic [CNT_W-1:0]    CNT_LAST   = {CNT_W{1'b1}};
  localparam logic [SCLK_BIT:0]   PHASE_LAST = {(SCLK_BIT + 1){1'b1}};
  // The word is loaded in the slot before the MSB slot to realise the I2S one-bit delay.
  localparam logic [SLOT_W-1:0]   LOAD_SLOT  = SLOT_W'(I2S_DELAY - 1);

endpackage

// File: rtl/i2s_ser.sv
// One-channel parallel-load shift register driving the I2S data line.
// Loads at the end of the load slot so the MSB occupies the next slot, then zero-fills.
module i2s_ser #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_end,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  output logic              sd
);

  logic [DATA_W-1:0] sr_r;
  logic [DATA_W-1:0] sr_nxt_s;
  logic              sd_r;
  logic              sd_nxt_s;

  // choose between parallel load and zero-filling shift at each bit boundary
  always_comb begin
    sr_nxt_s = sr_r;
    sd_nxt_s = sd_r;
    if (bit_end) begin
      if (load) begin
        sd_nxt_s = word[DATA_W-1];
        sr_nxt_s = {word[DATA_W-2:0], 1'b0};
      end else begin
        sd_nxt_s = sr_r[DATA_W-1];
        sr_nxt_s = {sr_r[DATA_W-2:0], 1'b0};
      end
    end else begin
      sr_nxt_s = sr_r;
      sd_nxt_s = sd_r;
    end
  end

  // shift register and serial output state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= {DATA_W{1'b0}};
      sd_r <= 1'b0;
    end else begin
      sr_r <= sr_nxt_s;
      sd_r <= sd_nxt_s;
    end
  end

  assign sd = sd_r;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter: derives MCLK/SCLK/LRCLK from one counter and serializes
// latched left/right samples MSB-first with the standard one-bit delay.
module i2s_dac_tx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] lft_smpl,
  input  logic [DATA_W-1:0] rht_smpl,
  input  logic              mute,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDout,
  output logic              smpl_taken
);

  import codec_pkg::*;

  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              latch_s;
  logic              bit_end_s;
  logic              load_s;
  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] lft_buf_r;
  logic [DATA_W-1:0] rht_buf_r;
  logic              mclk_r;
  logic              sclk_r;
  logic              lrclk_r;
  logic              taken_r;
  logic              sd_s;

  // counter successor, frame latch strobe, bit/slot strobes and channel select
  always_comb begin
    cnt_nxt_s = cnt_r + 11'd1;
    latch_s   = (cnt_r == CNT_LAST);
    bit_end_s = (cnt_r[SCLK_BIT:0] == PHASE_LAST);
    load_s    = (cnt_r[SCLK_BIT+SLOT_W:SCLK_BIT+1] == LOAD_SLOT);
    if (cnt_r[LRCLK_BIT]) begin
      word_s = rht_buf_r;
    end else begin
      word_s = lft_buf_r;
    end
  end

  // free-running counter; clock outputs track the counter value held this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      mclk_r  <= 1'b0;
      sclk_r  <= 1'b0;
      lrclk_r <= 1'b0;
      taken_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      mclk_r  <= cnt_nxt_s[MCLK_BIT];
      sclk_r  <= cnt_nxt_s[SCLK_BIT];
      lrclk_r <= cnt_nxt_s[LRCLK_BIT];
      taken_r <= latch_s;
    end
  end

  // frame latch: capture samples (or zeros when muted) once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_buf_r <= {DATA_W{1'b0}};
      rht_buf_r <= {DATA_W{1'b0}};
    end else if (latch_s) begin
      if (mute) begin
        lft_buf_r <= {DATA_W{1'b0}};
        rht_buf_r <= {DATA_W{1'b0}};
      end else begin
        lft_buf_r <= lft_smpl;
        rht_buf_r <= rht_smpl;
      end
    end
  end

  i2s_ser #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_end (bit_end_s),
    .load    (load_s),
    .word    (word_s),
    .sd      (sd_s)
  );

  assign MCLK       = mclk_r;
  assign SCLK       = sclk_r;
  assign LRCLK      = lrclk_r;
  assign SDout      = sd_s;
  assign smpl_taken = taken_r;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx: a frame scoreboard checks every DAC
// sample point, scenario tasks check clocks, latency, mute and reset behaviour.
module tb_i2s_dac_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] lft;
  logic [15:0] rht;
  logic        mute;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDout;
  logic        smpl_taken;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [10:0] m_cnt;
  logic        sb[$];
  logic [15:0] l_w;
  logic [15:0] r_w;

  i2s_dac_tx #(.DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lft_smpl   (lft),
    .rht_smpl   (rht),
    .mute       (mute),
    .MCLK       (MCLK),
    .SCLK       (SCLK),
    .LRCLK      (LRCLK),
    .SDout      (SDout),
    .smpl_taken (smpl_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference frame position: the counter value the DUT holds in the current clk
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 11'd0;
    else        m_cnt <= m_cnt + 11'd1;
  end

  // at each frame latch queue the 64 expected sample-point bits of the next frame
  always @(posedge clk) begin
    if (rst_n === 1'b1 && m_cnt == 11'd2047) begin
      l_w = mute ? 16'h0000 : lft;
      r_w = mute ? 16'h0000 : rht;
      for (int s = 0; s < 32; s++) sb.push_back((s >= 1 && s <= 16) ? l_w[16-s] : 1'b0);
      for (int s = 0; s < 32; s++) sb.push_back((s >= 1 && s <= 16) ? r_w[16-s] : 1'b0);
    end
  end

  // DAC sample point: SCLK has just risen (bit phase 16)
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_cnt[4:0] == 5'd16) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sdout_sb: no expected bit queued at cnt=%0d", m_cnt);
      end else begin
        logic exp_b;
        exp_b = sb.pop_front();
        if (SDout !== exp_b) begin
          errors++;
          $display("FAIL sdout_sb: cnt=%0d slot=%0d ch=%0d got %b expected %b",
                   m_cnt, m_cnt[9:5], m_cnt[10], SDout, exp_b);
        end
      end
    end
  end

  task automatic sb_reset();
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(1'b0);
  endtask

  task automatic wait_cnt(input logic [10:0] v);
    bit found = 1'b0;
    for (int n = 0; n < 2100 && !found; n++) begin
      @(negedge clk);
      if (m_cnt == v) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_cnt: cnt %0d not reached within budget", v);
    end
  endtask

  task automatic wait_latch();
    wait_cnt(11'd2047);
  endtask

  task automatic measure(input int idx, input int budget, output int period, output int high);
    int   rise1 = -1;
    int   rise2 = -1;
    int   fall  = -1;
    logic [2:0] v;
    logic prev;
    logic cur;
    v = {LRCLK, SCLK, MCLK};
    prev = v[idx];
    for (int n = 0; n < budget && rise2 < 0; n++) begin
      @(negedge clk);
      v = {LRCLK, SCLK, MCLK};
      cur = v[idx];
      if (!prev && cur) begin
        if (rise1 < 0) rise1 = cyc;
        else           rise2 = cyc;
      end
      if (prev && !cur && rise1 >= 0 && fall < 0) fall = cyc;
      prev = cur;
    end
    period = (rise1 >= 0 && rise2 >= 0) ? rise2 - rise1 : -1;
    high   = (rise1 >= 0 && fall >= 0) ? fall - rise1 : -1;
  endtask

  task automatic test_reset();
    int per;
    int hi;
    int exp_per[3] = '{4, 32, 2048};
    rst_n = 1'b0;
    lft = 16'h0000;
    rht = 16'h0000;
    mute = 1'b0;
    sb_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({MCLK, SCLK, LRCLK, SDout, smpl_taken} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 00000", {MCLK, SCLK, LRCLK, SDout, smpl_taken});
    end
    rst_n = 1'b1;
    wait_cnt(11'd1110);
    checks++;
    if ({MCLK, SCLK, LRCLK} !== 3'b111) begin
      errors++;
      $display("FAIL clocks_at_1110: got %b expected 111", {MCLK, SCLK, LRCLK});
    end
    rst_n = 1'b0;
    sb_reset();
    #1;
    checks++;
    if ({MCLK, SCLK, LRCLK, SDout, smpl_taken} !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000", {MCLK, SCLK, LRCLK, SDout, smpl_taken});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      measure(k, 2 * exp_per[k] + 100, per, hi);
      checks++;
      if (per != exp_per[k]) begin
        errors++;
        $display("FAIL period_%0d: got %0d expected %0d", k, per, exp_per[k]);
      end
      checks++;
      if (hi != exp_per[k] / 2) begin
        errors++;
        $display("FAIL high_time_%0d: got %0d expected %0d", k, hi, exp_per[k] / 2);
      end
    end
  endtask

  task automatic test_pattern();
    int pulses = 0;
    int first  = -1;
    int second = -1;
    lft = 16'hA5C3;
    rht = 16'h3C5A;
    wait_latch();
    for (int n = 0; n < 4096; n++) begin
      @(negedge clk);
      if (smpl_taken === 1'b1) begin
        pulses++;
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
        checks++;
        if (m_cnt != 11'd0) begin
          errors++;
          $display("FAIL taken_pos: pulse at cnt=%0d expected 0", m_cnt);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL taken_count: got %0d pulses expected 2", pulses);
    end
    checks++;
    if (second - first != 2048) begin
      errors++;
      $display("FAIL taken_spacing: got %0d expected 2048", second - first);
    end
  endtask

  task automatic test_full_scale();
    lft = 16'h8000;
    rht = 16'h7FFF;
    wait_latch();
    wait_cnt(11'd31);
    checks++;
    if (SDout !== 1'b0) begin
      errors++;
      $display("FAIL fs_slot0: got %b expected 0", SDout);
    end
    @(negedge clk);
    checks++;
    if (SDout !== 1'b1) begin
      errors++;
      $display("FAIL fs_msb_at_32: got %b expected 1", SDout);
    end
    wait_latch();
  endtask

  task automatic test_mute();
    int ones = 0;
    lft = 16'h5A5A;
    rht = 16'hC3C3;
    mute = 1'b0;
    wait_latch();
    wait_cnt(11'd600);
    mute = 1'b1;
    wait_latch();
    for (int n = 0; n < 2100; n++) begin
      @(negedge clk);
      if (m_cnt[4:0] == 5'd16 && SDout === 1'b1) ones++;
      if (m_cnt == 11'd100) mute = 1'b0;
      if (m_cnt == 11'd2047) break;
    end
    checks++;
    if (ones != 0) begin
      errors++;
      $display("FAIL muted_frame: got %0d one bits expected 0", ones);
    end
    ones = 0;
    for (int n = 0; n < 2100; n++) begin
      @(negedge clk);
      if (m_cnt[4:0] == 5'd16 && SDout === 1'b1) ones++;
      if (m_cnt == 11'd2047) break;
    end
    checks++;
    if (ones != $countones(lft) + $countones(rht)) begin
      errors++;
      $display("FAIL unmuted_frame: got %0d one bits expected %0d", ones,
               $countones(lft) + $countones(rht));
    end
  endtask

  task automatic test_mid_change();
    int ones = 0;
    lft = 16'h1234;
    rht = 16'hABCD;
    wait_latch();
    wait_cnt(11'd300);
    lft = 16'hFFFF;
    wait_latch();
    for (int n = 0; n < 2100; n++) begin
      @(negedge clk);
      if (m_cnt[4:0] == 5'd16 && !m_cnt[10] && SDout === 1'b1) ones++;
      if (m_cnt == 11'd2047) break;
    end
    checks++;
    if (ones != 16) begin
      errors++;
      $display("FAIL new_left_word: got %0d one bits expected 16", ones);
    end
  endtask

  task automatic test_reset_mid();
    lft = 16'hBEEF;
    rht = 16'h4F0F;
    wait_latch();
    wait_cnt(11'd1100);
    checks++;
    if ({LRCLK, SDout} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_right: got %b expected 11", {LRCLK, SDout});
    end
    rst_n = 1'b0;
    sb_reset();
    #1;
    checks++;
    if ({LRCLK, SDout} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 00", {LRCLK, SDout});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_latch();
    wait_latch();
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_full_scale();
    test_mute();
    test_mid_change();
    test_reset_mid();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
